mod_adder: RTL and testbench



---
 rtl/mod_adder.sv | 104 ++++++++++
 tb/tb_mod_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mod_adder.sv
`timescale 1ns/1ps
// mod_adder: two-stage pipelined modular adder.
// For each accepted operand set it returns (a + b) reduced by at most one
// subtraction of q, truncated to QW bits.
//
// Ports
//   clk_i    : clock, all registers rising-edge
//   rst_n_i  : asynchronous active-low reset, clears every register
//   valid_i  : qualifies a_i / b_i / q_i for sampling on this edge
//   a_i, b_i : DW-bit unsigned operands
//   q_i      : QW-bit unsigned modulus, sampled with the operands
//   valid_o  : result qualifier, high for one cycle per accepted input
//   c_o      : QW-bit result, holds the last valid result while valid_o is low
//
// Timing: operands sampled at edge k appear on c_o/valid_o after edge k+1.
// QW must be smaller than DW.
module mod_adder #(
   parameter int unsigned DW = 24,
   parameter int unsigned QW = 23
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          valid_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [QW-1:0] q_i,
   output logic          valid_o,
   output logic [QW-1:0] c_o
);

   // Sum keeps the carry; difference carries one extra bit as the borrow flag.
   localparam int unsigned SW  = DW + 1;
   localparam int unsigned DFW = DW + 2;

   logic [SW-1:0]     s_c;
   logic [DFW-1:0]    d_c;
   logic              borrow_c;
   logic [QW-1:0]     d_lo_c;
   logic [DFW-2:QW]   d_unused_c;

   // Stage-1 registers
   logic              vld1_q, vld1_d;
   logic              borrow1_q, borrow1_d;
   logic [QW-1:0]     s_lo1_q, s_lo1_d;
   logic [QW-1:0]     d_lo1_q, d_lo1_d;

   // Stage-2 (output) registers
   logic              vld2_q, vld2_d;
   logic [QW-1:0]     c_q, c_d;

   // Full-width sum and difference; the difference top bit is set exactly when s < q.
   assign s_c      = SW'(a_i) + SW'(b_i);
   assign d_c      = DFW'(s_c) - DFW'(q_i);
   assign borrow_c = d_c[DFW-1];
   assign d_lo_c   = d_c[QW-1:0];
   // Middle difference bits never reach the result (truncation to QW bits).
   assign d_unused_c = d_c[DFW-2:QW];

   // Stage-1 next state: only the low QW bits of s and d can ever be selected,
   // so only those are kept; data registers hold when no operand is offered.
   always_comb begin
      vld1_d    = valid_i;
      borrow1_d = borrow1_q;
      s_lo1_d   = s_lo1_q;
      d_lo1_d   = d_lo1_q;
      if (valid_i) begin
         borrow1_d = borrow_c;
         s_lo1_d   = s_c[QW-1:0];
         d_lo1_d   = d_lo_c;
      end
   end

   // Stage-2 next state: single conditional subtraction, result held between valids.
   always_comb begin
      vld2_d = vld1_q;
      c_d    = c_q;
      if (vld1_q) begin
         c_d = borrow1_q ? s_lo1_q : d_lo1_q;
      end
   end

   // Pipeline registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld1_q    <= 1'b0;
         borrow1_q <= 1'b0;
         s_lo1_q   <= '0;
         d_lo1_q   <= '0;
         vld2_q    <= 1'b0;
         c_q       <= '0;
      end else begin
         vld1_q    <= vld1_d;
         borrow1_q <= borrow1_d;
         s_lo1_q   <= s_lo1_d;
         d_lo1_q   <= d_lo1_d;
         vld2_q    <= vld2_d;
         c_q       <= c_d;
      end
   end

   assign valid_o = vld2_q;
   assign c_o     = c_q;

endmodule

// File: tb/tb_mod_adder.sv
`timescale 1ns/1ps
// tb_mod_adder: table vectors, random stream with gaps and a mid-stream reset,
// all results checked in order against a queue of expected values.
module tb_mod_adder;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        valid_i;
   logic [23:0] a_i, b_i;
   logic [22:0] q_i;
   logic        valid_o;
   logic [22:0] c_o;

   int total = 0;
   int bad   = 0;
   logic [22:0] exp_q[$];

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [22:0] q;
      logic [22:0] exp;
   } vec_t;

   vec_t vecs[5];

   mod_adder #(.DW(24), .QW(23)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .q_i     (q_i),
      .valid_o (valid_o),
      .c_o     (c_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: one conditional subtraction, result truncated to 23 bits.
   function automatic logic [22:0] model(input logic [23:0] a, input logic [23:0] b,
                                         input logic [22:0] q);
      logic [24:0] s;
      logic [24:0] r;
      s = {1'b0, a} + {1'b0, b};
      if (s < {2'b00, q}) r = s;
      else                r = s - {2'b00, q};
      return r[22:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Drive one cycle of stimulus; expected result queued only for valid ops.
   task automatic drive(input logic v, input logic [23:0] a, input logic [23:0] b,
                        input logic [22:0] q, input logic push);
      @(negedge clk_i);
      valid_i = v;
      a_i = a;
      b_i = b;
      q_i = q;
      if (v && push) exp_q.push_back(model(a, b, q));
      @(posedge clk_i);
   endtask

   task automatic idle();
      drive(1'b0, 24'($urandom), 24'($urandom), 23'($urandom), 1'b0);
   endtask

   // Monitor: every valid_o must match the oldest outstanding expectation.
   always @(posedge clk_i) begin
      #1;
      if (valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious valid_o", 32'(valid_o), 32'd0);
         end else begin
            check("result", 32'(c_o), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      vecs[0] = '{a: 24'h000005, b: 24'h000007, q: 23'h7FE001, exp: 23'h00000C};
      vecs[1] = '{a: 24'h7FE000, b: 24'h000001, q: 23'h7FE001, exp: 23'h000000};
      vecs[2] = '{a: 24'h7FE000, b: 24'h7FE000, q: 23'h7FE001, exp: 23'h7FDFFF};
      vecs[3] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, q: 23'h000000, exp: 23'h7FFFFE};
      vecs[4] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, q: 23'h7FFFFF, exp: 23'h7FFFFF};

      rst_n_i = 1'b0;
      valid_i = 1'b0;
      a_i = '0;
      b_i = '0;
      q_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset valid_o", 32'(valid_o), 32'd0);
      check("reset c_o", 32'(c_o), 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Directed vectors: spec constants go to the queue, then the held value is checked.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         valid_i = 1'b1;
         a_i = vecs[i].a;
         b_i = vecs[i].b;
         q_i = vecs[i].q;
         exp_q.push_back(vecs[i].exp);
         @(posedge clk_i);
         idle();
         idle();
         @(negedge clk_i);
         check("hold valid_o low", 32'(valid_o), 32'd0);
         check("hold c_o", 32'(c_o), 32'(vecs[i].exp));
      end

      // Random stream, valid mostly high with occasional gaps.
      for (int n = 0; n < 1000; ) begin
         if ($urandom_range(0, 5) == 0) begin
            idle();
         end else begin
            drive(1'b1, 24'($urandom), 24'($urandom), 23'($urandom), 1'b1);
            n++;
         end
      end
      repeat (3) idle();
      check("stream drained", 32'(exp_q.size()), 32'd0);

      // Mid-stream reset: one op in stage 1, another on the inputs, c_o nonzero.
      drive(1'b1, 24'd5, 24'd7, 23'h7FE001, 1'b1);
      idle();
      idle();
      @(negedge clk_i);
      check("pre-reset c_o", 32'(c_o), 32'h00000C);
      valid_i = 1'b1;
      a_i = 24'h123456;
      b_i = 24'h654321;
      q_i = 23'h7FE001;
      @(posedge clk_i);
      @(negedge clk_i);
      a_i = 24'h0ABCDE;
      b_i = 24'h111111;
      #1;
      rst_n_i = 1'b0;
      #1;
      check("async reset valid_o", 32'(valid_o), 32'd0);
      check("async reset c_o", 32'(c_o), 32'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      rst_n_i = 1'b1;
      repeat (4) idle();
      @(negedge clk_i);
      check("post-reset c_o", 32'(c_o), 32'd0);
      check("post-reset queue", 32'(exp_q.size()), 32'd0);

      // Pipeline still works after reset.
      drive(1'b1, 24'd1, 24'd2, 23'h7FE001, 1'b1);
      repeat (3) idle();
      @(negedge clk_i);
      check("post-reset op c_o", 32'(c_o), 32'd3);
      check("final drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
